// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides.
// S1 holds the accepted operands, S2 holds the registered result and flags.
module alu_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] op_cnt
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    logic             s1_vld;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_adv;
    logic             out_xfer;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic [SH_W-1:0]  sh;

    logic [WIDTH-1:0] res;
    logic             res_err;
    logic             res_ovf;
    logic             res_carry;
    logic             res_zero;

    // S2 drains when empty or when downstream takes the beat; S1 follows it.
    assign s2_adv   = !out_vld || out_rdy;
    assign in_rdy   = reset_n && (!s1_vld || s2_adv);
    assign out_xfer = out_vld && out_rdy;

    // Operand stage: only captured on a real transfer so idle inputs never leak in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s1_op  <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
        end else if (in_rdy) begin
            s1_vld <= in_vld;
            if (in_vld) begin
                s1_op <= opcode;
                s1_a  <= a;
                s1_b  <= b;
            end
        end
    end

    assign sum_ext = {1'b0, s1_a} + {1'b0, s1_b};
    assign dif_ext = {1'b0, s1_a} - {1'b0, s1_b};
    assign sh      = s1_b[SH_W-1:0];

    // Result and flag generation from the S1 operands.
    always_comb begin
        res       = '0;
        res_err   = 1'b0;
        res_ovf   = 1'b0;
        res_carry = 1'b0;
        case (s1_op)
            OP_PASS: res = s1_a;
            OP_ADD: begin
                res       = sum_ext[WIDTH-1:0];
                res_carry = sum_ext[WIDTH];
                res_ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                res       = dif_ext[WIDTH-1:0];
                res_carry = dif_ext[WIDTH];
                res_ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                            (dif_ext[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_OR:   res = s1_a | s1_b;
            OP_AND:  res = s1_a & s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            OP_NOT:  res = ~s1_a;
            OP_SHL:  res = s1_a << sh;
            OP_SHR:  res = s1_a >> sh;
            OP_SRA:  res = WIDTH'($signed(s1_a) >>> sh);
            default: res_err = 1'b1;
        endcase
        res_zero = (res == '0);
    end

    // Result stage: frozen while a beat waits for downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld <= 1'b0;
            out     <= '0;
            flags   <= '0;
        end else if (s2_adv) begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                out   <= res;
                flags <= {res_err, res_ovf, res_carry, res_zero};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_cnt <= '0;
        end else if (out_xfer) begin
            op_cnt <= op_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected beats are queued on input transfer
// and compared on output transfer; directed steps run in one initial block.
module tb_alu_pipe;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_vld;
    logic          in_rdy;
    logic [3:0]    opcode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_vld;
    logic          out_rdy;
    logic [W-1:0]  out;
    logic [3:0]    flags;
    logic [CW-1:0] op_cnt;

    int            total = 0;
    int            bad   = 0;
    logic [19:0]   sb_q[$];
    logic [CW-1:0] exp_cnt;
    logic          prev_stall;
    logic [19:0]   prev_res;

    alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .opcode  (opcode),
        .a       (a),
        .b       (b),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out     (out),
        .flags   (flags),
        .op_cnt  (op_cnt)
    );

    always #5 clk = ~clk;

    // Reference model returning {err, ovf, carry, zero, out}.
    function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] x,
                                          input logic [15:0] y);
        int ux, uy, sx, sy, r, sh;
        logic err, ovf, cy;
        logic [15:0] res;
        ux  = int'(x);
        uy  = int'(y);
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        sh  = int'(y[3:0]);
        err = 1'b0;
        ovf = 1'b0;
        cy  = 1'b0;
        r   = 0;
        case (op)
            4'd0: r = ux;
            4'd1: begin
                r   = ux + uy;
                cy  = (r > 65535);
                ovf = (sx + sy > 32767) || (sx + sy < -32768);
            end
            4'd2: begin
                r   = ux - uy;
                cy  = (ux < uy);
                ovf = (sx - sy > 32767) || (sx - sy < -32768);
            end
            4'd3: r = ux | uy;
            4'd4: r = ux & uy;
            4'd5: r = ux ^ uy;
            4'd6: r = 65535 - ux;
            4'd7: r = ux << sh;
            4'd8: r = ux >> sh;
            4'd9: r = sx >>> sh;
            default: err = 1'b1;
        endcase
        res = r[15:0];
        return {err, ovf, cy, (res == 16'd0), res};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then advance past the rising edge.
    task automatic tick(output logic took);
        @(negedge clk);
        took = 1'b0;
        if (reset_n) begin
            if (prev_stall)
                chk("hold", 32'({out_vld, flags, out}), 32'({1'b1, prev_res}));
            chk("op_cnt", 32'(op_cnt), 32'(exp_cnt));
            if (out_vld && out_rdy) begin
                if (sb_q.size() == 0)
                    chk("stale_beat", 32'(out_vld), 32'(0));
                else
                    chk("result", 32'({flags, out}), 32'(sb_q.pop_front()));
                exp_cnt = exp_cnt + CW'(1);
            end
            if (in_vld && in_rdy) begin
                sb_q.push_back(model(opcode, a, b));
                took = 1'b1;
            end
            prev_stall = out_vld && !out_rdy;
            prev_res   = {flags, out};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_vld  = 1'b0;
        #1;
        chk("rst_out_vld", 32'(out_vld), 32'(0));
        chk("rst_op_cnt", 32'(op_cnt), 32'(0));
        chk("rst_in_rdy", 32'(in_rdy), 32'(0));
        chk("rst_out_flags", 32'({flags, out}), 32'(0));
        sb_q.delete();
        exp_cnt    = '0;
        prev_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 32'(in_rdy), 32'(1));
    endtask

    task automatic drain();
        logic took;
        out_rdy = 1'b1;
        in_vld  = 1'b0;
        for (int t = 0; t < 50 && (sb_q.size() != 0 || out_vld); t++) tick(took);
        chk("drain", 32'(sb_q.size()), 32'(0));
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        logic took;
        took   = 1'b0;
        opcode = op;
        a      = x;
        b      = y;
        in_vld = 1'b1;
        for (int t = 0; t < 50 && !took; t++) tick(took);
        in_vld = 1'b0;
        chk("send", 32'(took), 32'(1));
    endtask

    // Single beat on an idle pipe: result must be valid two edges after the transfer.
    task automatic one(input string tag, input logic [3:0] op, input logic [15:0] x,
                       input logic [15:0] y, input logic [19:0] expv);
        logic took;
        out_rdy = 1'b1;
        opcode  = op;
        a       = x;
        b       = y;
        in_vld  = 1'b1;
        tick(took);
        in_vld  = 1'b0;
        opcode  = 4'($urandom_range(0, 15));
        a       = 16'($urandom);
        b       = 16'($urandom);
        tick(took);
        chk({tag, "_vld"}, 32'(out_vld), 32'(1));
        chk(tag, 32'({flags, out}), 32'(expv));
        tick(took);
    endtask

    task automatic stream(input int n, input bit rnd);
        int sent;
        logic took;
        sent = 0;
        for (int t = 0; t < 2000 && sent < n; t++) begin
            out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_vld  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            opcode  = rnd ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            a       = 16'($urandom);
            b       = 16'($urandom);
            if (!rnd) begin
                #1;
                chk("full_rate", 32'(in_rdy), 32'(1));
            end
            tick(took);
            if (took) sent++;
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        chk("stream_sent", 32'(sent), 32'(n));
    endtask

    initial begin
        logic took;
        int   sent;
        reset_n    = 1'b1;
        in_vld     = 1'b0;
        out_rdy    = 1'b1;
        opcode     = '0;
        a          = '0;
        b          = '0;
        exp_cnt    = '0;
        prev_stall = 1'b0;
        prev_res   = '0;
        #2;
        do_reset();

        // Add wrap with carry, then subtract overflow/borrow, shifts and illegal opcode.
        one("add_wrap", 4'd1, 16'hFFFF, 16'h0001, {4'b0011, 16'h0000});
        chk("cnt_one", 32'(op_cnt), 32'(1));
        one("sub_ovf",  4'd2, 16'h8000, 16'h0001, {4'b0100, 16'h7FFF});
        one("sub_brw",  4'd2, 16'h0003, 16'h0005, {4'b0010, 16'hFFFE});
        one("sra",      4'd9, 16'h8000, 16'h0004, {4'b0000, 16'hF800});
        one("srl",      4'd8, 16'h8000, 16'h0004, {4'b0000, 16'h0800});
        one("illegal",  4'd12, 16'h1234, 16'h5678, {4'b1001, 16'h0000});
        one("not_zero", 4'd6, 16'hFFFF, 16'h0000, {4'b0001, 16'h0000});
        one("shl",      4'd7, 16'h0001, 16'h00FF, {4'b0000, 16'h8000});
        drain();

        // Ten back-to-back beats with a three-cycle downstream stall after the first result.
        do_reset();
        sent = 0;
        for (int t = 0; t < 80 && (sent < 10 || sb_q.size() != 0 || out_vld); t++) begin
            out_rdy = !(t == 3 || t == 4 || t == 5);
            in_vld  = (sent < 10);
            opcode  = 4'(sent % 10);
            a       = 16'($urandom);
            b       = 16'($urandom);
            #1;
            if (t == 4 || t == 5) chk("stall_in_rdy", 32'(in_rdy), 32'(0));
            tick(took);
            if (took) sent++;
        end
        in_vld = 1'b0;
        drain();
        chk("cnt_ten", 32'(op_cnt), 32'(10));

        // Reset with two beats in flight: nothing may emerge afterwards.
        do_reset();
        out_rdy = 1'b0;
        send(4'd1, 16'h0011, 16'h0022);
        send(4'd3, 16'h00F0, 16'h000F);
        chk("inflight", 32'(out_vld), 32'(1));
        do_reset();
        out_rdy = 1'b1;
        for (int t = 0; t < 6; t++) tick(took);
        chk("no_stale", 32'(out_vld), 32'(0));
        chk("cnt_after_rst", 32'(op_cnt), 32'(0));

        // Seventeen full-rate transfers wrap the 4-bit counter to 1.
        do_reset();
        stream(17, 1'b0);
        drain();
        chk("cnt_wrap", 32'(op_cnt), 32'(1));

        // Random opcodes, operands, input gaps and downstream backpressure.
        do_reset();
        stream(60, 1'b1);
        drain();
        chk("cnt_rand", 32'(op_cnt), 32'(60 % 16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
